// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle for the register-file slave: AW, W, B, AR and R channels.
// The slave modport is used by axil_regfile_slave; the master modport by whoever drives it.
interface axil_regfile_slave_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS words of DATA_W bits, byte-strobed writes, independent read path.
// Optional AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regfile_slave #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input logic                 ACLK,
    input logic                 ARESETn,
    axil_regfile_slave_if.slave axil
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFFS;
    localparam int REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NUM_REGS_C = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              aw_full, w_full;
    logic              awready_q, wready_q;
    logic [IDX_W-1:0]  aw_idx;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    r_state_t          r_state, r_state_next;
    logic              arready_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic              aw_full_next, w_full_next;
    logic [IDX_W-1:0]  ar_idx;
    logic              wr_in_range, rd_in_range;
    logic              unused_addr_bits;

    assign aw_hs  = axil.AWVALID && awready_q;
    assign w_hs   = axil.WVALID && wready_q;
    assign ar_hs  = axil.ARVALID && arready_q;
    assign commit = aw_full && w_full && (!bvalid_q || axil.BREADY);

    // A handshake only happens into an empty slot, so capture and commit never collide.
    assign aw_full_next = aw_hs || (aw_full && !commit);
    assign w_full_next  = w_hs || (w_full && !commit);

    assign ar_idx      = axil.ARADDR[ADDR_W-1:OFFS];
    assign wr_in_range = {1'b0, aw_idx} < NUM_REGS_C;
    assign rd_in_range = {1'b0, ar_idx} < NUM_REGS_C;

    // Byte-offset bits inside a word carry no meaning for this slave.
    assign unused_addr_bits = ^{axil.AWADDR[OFFS-1:0], axil.ARADDR[OFFS-1:0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_idx    <= '0;
            w_data    <= '0;
            w_strb    <= '0;
        end else begin
            aw_full   <= aw_full_next;
            w_full    <= w_full_next;
            awready_q <= !aw_full_next;
            wready_q  <= !w_full_next;
            if (aw_hs) begin
                aw_idx <= axil.AWADDR[ADDR_W-1:OFFS];
            end
            if (w_hs) begin
                w_data <= axil.WDATA;
                w_strb <= axil.WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_in_range ? RESP_OKAY : RESP_OOR;
                if (wr_in_range) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb[b]) begin
                            regs[aw_idx[REG_IW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                end
            end else if (bvalid_q && axil.BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_RESP;
            R_RESP:  if (axil.RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Register reads sample the array before any same-edge commit lands.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_next;
            arready_q <= (r_state_next == R_IDLE);
            if (ar_hs) begin
                rdata_q <= rd_in_range ? regs[ar_idx[REG_IW-1:0]] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    assign axil.AWREADY = awready_q;
    assign axil.WREADY  = wready_q;
    assign axil.BVALID  = bvalid_q;
    assign axil.BRESP   = bresp_q;
    assign axil.ARREADY = arready_q;
    assign axil.RVALID  = (r_state == R_RESP);
    assign axil.RDATA   = rdata_q;
    assign axil.RRESP   = rresp_q;
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave: directed bus scenarios plus random traffic against a word-array model.
// Build with or without AXIL_SLVERR_EN; the expected out-of-range response follows the macro.
module tb_axil_regfile_slave;
    localparam int NREGS = 16;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] EXP_ERR = 2'b10;
`else
    localparam logic [1:0] EXP_ERR = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] model [NREGS];
    logic [31:0] rd;
    logic [1:0]  rr, br;

    axil_regfile_slave_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    axil_regfile_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(NREGS)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .axil    (bus)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic bit in_range(input logic [7:0] a);
        return int'(a) / 4 < NREGS;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_range(a)) model[int'(a) / 4] = merge(model[int'(a) / 4], d, s);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return in_range(a) ? model[int'(a) / 4] : 32'h0;
    endfunction

    // Write with B free: expects BVALID exactly one cycle after the later of AW/W.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit hs_aw, hs_w;
        int n = 0;
        bus.BREADY = 1'b1;
        bus.AWADDR = a;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        while (!(aw_done && w_done) && n < 100) begin
            if (w_done && !aw_done) begin
                check("wait_w_wready", bus.WREADY, 1'b0);
                check("wait_w_awready", bus.AWREADY, 1'b1);
            end
            if (aw_done && !w_done) begin
                check("wait_aw_awready", bus.AWREADY, 1'b0);
                check("wait_aw_wready", bus.WREADY, 1'b1);
            end
            bus.AWVALID = !aw_done && (n >= aw_dly);
            bus.WVALID  = !w_done && (n >= w_dly);
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            n++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("wr_hs_done", {aw_done, w_done}, 2'b11);
        check("wr_bvalid_early", bus.BVALID, 1'b0);
        @(posedge ACLK); #1;
        check("wr_bvalid_lat", bus.BVALID, 1'b1);
        resp = bus.BRESP;
        @(posedge ACLK); #1;
        check("wr_bvalid_drop", bus.BVALID, 1'b0);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        bit done = 0;
        bit hs;
        int n = 0;
        bus.RREADY = 1'b1;
        bus.ARADDR = a;
        while (!done && n < 100) begin
            bus.ARVALID = 1'b1;
            hs = bus.ARREADY;
            @(posedge ACLK); #1;
            n++;
            if (hs) done = 1;
        end
        bus.ARVALID = 1'b0;
        check("rd_ar_done", done, 1'b1);
        check("rd_rvalid_lat", bus.RVALID, 1'b1);
        d = bus.RDATA;
        r = bus.RRESP;
        @(posedge ACLK); #1;
        check("rd_rvalid_drop", bus.RVALID, 1'b0);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;

        bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
        bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;

        // reset values
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", bus.AWREADY, 1'b0);
        check("rst_wready", bus.WREADY, 1'b0);
        check("rst_arready", bus.ARREADY, 1'b0);
        check("rst_bvalid", bus.BVALID, 1'b0);
        check("rst_rvalid", bus.RVALID, 1'b0);
        check("rst_rdata", bus.RDATA, 32'h0);
        check("rst_resps", {bus.BRESP, bus.RRESP}, 4'h0);
        #2 ARESETn = 1'b1;
        #1 check("rst_rel_ready_low", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        check("rst_rel_ready_high", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        // simultaneous AW/W full-word write and readback
        axi_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, br);
        model_write(8'h04, 32'hDEADBEEF, 4'hF);
        check("w04_bresp", br, 2'b00);
        axi_read(8'h04, rd, rr);
        check("r04_data", rd, 32'hDEADBEEF);
        check("r04_rresp", rr, 2'b00);

        // partial strobes
        axi_write(8'h04, 32'h11223344, 4'b0101, 0, 0, br);
        model_write(8'h04, 32'h11223344, 4'b0101);
        axi_read(8'h04, rd, rr);
        check("strb_data", rd, 32'hDE22BE44);
        check("strb_model", rd, model_read(8'h04));

        // zero strobe still responds, changes nothing
        axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 1, 0, br);
        check("strb0_bresp", br, 2'b00);
        axi_read(8'h05, rd, rr);
        check("strb0_data", rd, 32'hDE22BE44);

        // W three cycles ahead of AW
        axi_write(8'h0C, 32'hCAFEF00D, 4'hF, 3, 0, br);
        model_write(8'h0C, 32'hCAFEF00D, 4'hF);
        check("wfirst_bresp", br, 2'b00);

        // B back-pressure with a second write queued in holding
        bus.BREADY = 1'b0;
        bus.AWADDR = 8'h08; bus.WDATA = 32'hAAAA5555; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(posedge ACLK); #1;
        check("bp_b1_valid", bus.BVALID, 1'b1);
        check("bp_b1_resp", bus.BRESP, 2'b00);
        model_write(8'h08, 32'hAAAA5555, 4'hF);
        bus.WDATA = 32'h12345678; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check("bp_b2_held", {bus.AWREADY, bus.WREADY}, 2'b00);
        axi_read(8'h08, rd, rr);
        check("bp_reg_unchanged", rd, model_read(8'h08));
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            check("bp_b1_hold", {bus.BVALID, bus.BRESP}, 3'b100);
            check("bp_aw_still_full", bus.AWREADY, 1'b0);
        end
        bus.BREADY = 1'b1;
        @(posedge ACLK); #1;
        model_write(8'h08, 32'h12345678, 4'hF);
        check("bp_b2_valid", bus.BVALID, 1'b1);
        check("bp_aw_free", {bus.AWREADY, bus.WREADY}, 2'b11);
        @(posedge ACLK); #1;
        check("bp_b2_retired", bus.BVALID, 1'b0);
        axi_read(8'h08, rd, rr);
        check("bp_reg_new", rd, 32'h12345678);

        // out-of-range index 16
        axi_write(8'h40, 32'h0BADF00D, 4'hF, 0, 2, br);
        check("oor_bresp", br, EXP_ERR);
        axi_read(8'h40, rd, rr);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", rr, EXP_ERR);
        axi_read(8'h00, rd, rr);
        check("oor_reg0", rd, model_read(8'h00));

        // reset with B and R pending plus a write held
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        bus.AWADDR = 8'h0C; bus.WDATA = 32'h5A5A5A5A; bus.WSTRB = 4'hF;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 8'h04; bus.ARVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        @(posedge ACLK); #1;
        check("rstmid_bvalid_pre", bus.BVALID, 1'b1);
        check("rstmid_rvalid_pre", bus.RVALID, 1'b1);
        bus.AWADDR = 8'h10; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        check("rstmid_valids", {bus.BVALID, bus.RVALID}, 2'b00);
        check("rstmid_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        repeat (2) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge ACLK); #1;
            check("rstmid_no_stale", {bus.BVALID, bus.RVALID}, 2'b00);
        end
        axi_read(8'h04, rd, rr);
        check("rstmid_r04", rd, 32'h0);
        axi_read(8'h0C, rd, rr);
        check("rstmid_r0c", rd, 32'h0);
        axi_read(8'h10, rd, rr);
        check("rstmid_r10", rd, 32'h0);

        // random traffic
        for (int it = 0; it < 80; it++) begin
            a = 8'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), br);
                check("rnd_bresp", br, in_range(a) ? 2'b00 : EXP_ERR);
                model_write(a, d, s);
            end else begin
                axi_read(a, rd, rr);
                check("rnd_rdata", rd, model_read(a));
                check("rnd_rresp", rr, in_range(a) ? 2'b00 : EXP_ERR);
            end
        end

        for (int i = 0; i < NREGS; i++) begin
            axi_read(8'(i * 4), rd, rr);
            check("sweep", rd, model[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axil_regfile_slave.md
AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of AWADDR/ARADDR.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values 32 and 64.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of DATA_W-wide registers; legal range 1..2^(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have port ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have AW ports: AWADDR in ADDR_W write address; AWVALID in 1; AWREADY out 1.
REQ-007 SHALL have W ports: WDATA in DATA_W; WSTRB in DATA_W/8 byte enables; WVALID in 1; WREADY out 1.
REQ-008 SHALL have B ports: BRESP out 2 write response; BVALID out 1; BREADY in 1.
REQ-009 SHALL have AR ports: ARADDR in ADDR_W read address; ARVALID in 1; ARREADY out 1.
REQ-010 SHALL have R ports: RDATA out DATA_W; RRESP out 2 read response; RVALID out 1; RREADY in 1.

Function
REQ-011 SHALL decode register index = ADDR[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits ignored; index >= NUM_REGS is out-of-range.
REQ-012 SHALL capture AW and W independently in one-entry holding registers (aw_full, w_full); AWREADY = !aw_full, WREADY = !w_full, both registered.
REQ-013 SHALL commit a write on the rising edge where aw_full && w_full && (!BVALID || BREADY), clearing both holding registers on that edge.
REQ-014 SHALL on commit update byte lane i of the addressed register iff WSTRB[i]=1; other lanes unchanged; WSTRB=0 writes nothing but still responds.
REQ-015 SHALL assert BVALID from the commit edge, holding BVALID/BRESP stable until the BREADY handshake.
REQ-016 SHALL give write latency: BVALID high exactly one cycle after the later of the AW/W handshakes, when B is free.
REQ-017 SHALL accept a next AW/W into holding while BVALID is pending, without committing it until REQ-013 holds.
REQ-018 SHALL implement read FSM R_IDLE -> R_RESP on AR handshake; R_RESP -> R_IDLE on RVALID&&RREADY; ARREADY = (state==R_IDLE).
REQ-019 SHALL register RDATA/RRESP on the AR handshake edge, asserting RVALID the next cycle and holding RDATA/RRESP stable until the RREADY handshake.
REQ-020 SHALL, when a read and a commit target the same register on the same edge, return the pre-write value.
REQ-021 SHALL return OKAY (2'b00) for in-range accesses.
REQ-022 SHALL treat read and write paths as fully independent, neither stalling the other.

Reset
REQ-023 SHALL, while ARESETn=0, drive all registers 0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0, read FSM=R_IDLE, holding registers empty.
REQ-024 SHALL assert AWREADY, WREADY and ARREADY from the first rising edge after ARESETn deasserts.
REQ-025 SHALL on reset mid-transaction discard all held and pending transactions, issuing no response for them.

Configuration
REQ-026 SHALL, with AXIL_SLVERR_EN defined, respond SLVERR (2'b10) to out-of-range accesses, discarding writes and returning RDATA=0.
REQ-027 SHALL, with AXIL_SLVERR_EN undefined, respond OKAY to out-of-range accesses, still discarding writes and returning RDATA=0.

Verification
REQ-028 SHALL cover: AW=0x04, W=0xDEADBEEF, WSTRB=0xF, same cycle, BREADY=1 -> BVALID one cycle later with BRESP=0; read 0x04 -> RDATA=0xDEADBEEF, RRESP=0.
REQ-029 SHALL cover: reg 0x04=0xDEADBEEF, write 0x11223344 with WSTRB=0b0101 -> readback 0xDE22BE44.
REQ-030 SHALL cover: W presented 3 cycles before AW -> WREADY low and AWREADY high while waiting; BVALID one cycle after AW handshake.
REQ-031 SHALL cover: BREADY low 5 cycles with a second write issued -> first BVALID held stable; second AW/W accepted but register unchanged until first B handshake; second BVALID follows one cycle after it.
REQ-032 SHALL cover: write/read 0x40 (index 16) -> BRESP=RRESP=2'b10 with AXIL_SLVERR_EN, 2'b00 without; RDATA=0; all registers unchanged.
REQ-033 SHALL cover: ARESETn pulsed low with BVALID and RVALID pending -> both drop immediately, registers read 0, no stale response after reset.
